// File: rtl/dr_phase_ctrl.sv
// Clocked dual-rail phase controller: completion detection, R_c/R_m decode and RTZ handshake.
// Optional macro DR_SYNC_EN adds 2-flop synchronisers on all ph/cmd rails and both acks.
module dr_phase_ctrl #(
    parameter int NCH    = 2,
    parameter int RD_IDX = 0,
    parameter int LD_IDX = 1,
    parameter int TO_W   = 8,
    parameter int TO_MAX = 200
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     ph_t,
    input  logic [1:0]     ph_f,
    input  logic [NCH-1:0] cmd_t,
    input  logic [NCH-1:0] cmd_f,
    input  logic           ack_c,
    input  logic           ack_m,
    input  logic           err_clr,
    output logic           r_c_t,
    output logic           r_c_f,
    output logic           r_m_t,
    output logic           r_m_f,
    output logic           busy,
    output logic           code_err,
    output logic           to_err
);

    // state | meaning
    // NUL   | waiting for all inputs to return to NULL
    // DAT   | waiting for a complete, legal DATA wavefront
    // REQ   | request rails driven, waiting for both acks high
    // RTZ   | request rails NULL, waiting for both acks low
    typedef enum logic [1:0] {NUL, DAT, REQ, RTZ} state_t;

    localparam int SW = 2*NCH + 6;
    localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(TO_MAX);

    state_t          state;
    logic [TO_W-1:0] cnt;
    logic [TO_W:0]   cnt_inc;

    logic [1:0]     s_ph_t, s_ph_f;
    logic [NCH-1:0] s_cmd_t, s_cmd_f;
    logic           s_ack_c, s_ack_m;

`ifdef DR_SYNC_EN
    logic [SW-1:0] sync1, sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {ph_t, ph_f, cmd_t, cmd_f, ack_c, ack_m};
            sync2 <= sync1;
        end
    end

    assign {s_ph_t, s_ph_f, s_cmd_t, s_cmd_f, s_ack_c, s_ack_m} = sync2;
`else
    logic [SW-1:0] raw_in;

    assign raw_in = {ph_t, ph_f, cmd_t, cmd_f, ack_c, ack_m};
    assign {s_ph_t, s_ph_f, s_cmd_t, s_cmd_f, s_ack_c, s_ack_m} = raw_in;
`endif

    logic all_data, all_null, any_ill;
    logic ph0_t, ph0_f, ph1_t, rd_t, ld_t;
    logic dec_c, dec_m;
    logic acks_hi, acks_lo, timeout;

    assign all_data = (&(s_ph_t ^ s_ph_f)) & (&(s_cmd_t ^ s_cmd_f));
    assign all_null = ~|{s_ph_t, s_ph_f, s_cmd_t, s_cmd_f};
    assign any_ill  = (|(s_ph_t & s_ph_f)) | (|(s_cmd_t & s_cmd_f));

    assign ph0_t = s_ph_t[0] & ~s_ph_f[0];
    assign ph0_f = s_ph_f[0] & ~s_ph_t[0];
    assign ph1_t = s_ph_t[1] & ~s_ph_f[1];
    assign rd_t  = s_cmd_t[RD_IDX] & ~s_cmd_f[RD_IDX];
    assign ld_t  = s_cmd_t[LD_IDX] & ~s_cmd_f[LD_IDX];

    assign dec_c = ph0_f & ph1_t & rd_t;
    assign dec_m = ph0_t | (ph1_t & ld_t);

    assign acks_hi = s_ack_c & s_ack_m;
    assign acks_lo = ~s_ack_c & ~s_ack_m;
    assign cnt_inc = {1'b0, cnt} + (TO_W+1)'(1);
    assign timeout = (cnt_inc == TO_LIM);

    assign busy = (state != NUL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= NUL;
            cnt      <= '0;
            r_c_t    <= 1'b0;
            r_c_f    <= 1'b0;
            r_m_t    <= 1'b0;
            r_m_f    <= 1'b0;
            code_err <= 1'b0;
            to_err   <= 1'b0;
        end else begin
            // Clear first so a same-cycle set below overrides it
            if (err_clr) begin
                code_err <= 1'b0;
                to_err   <= 1'b0;
            end
            case (state)
                NUL: begin
                    if (all_null) state <= DAT;
                end
                DAT: begin
                    if (any_ill) begin
                        code_err <= 1'b1;
                    end else if (all_data) begin
                        state <= REQ;
                        cnt   <= '0;
                        r_c_t <= dec_c;
                        r_c_f <= ~dec_c;
                        r_m_t <= dec_m;
                        r_m_f <= ~dec_m;
                    end
                end
                REQ: begin
                    if (acks_hi || timeout) begin
                        state <= acks_hi ? RTZ : NUL;
                        cnt   <= '0;
                        r_c_t <= 1'b0;
                        r_c_f <= 1'b0;
                        r_m_t <= 1'b0;
                        r_m_f <= 1'b0;
                        if (!acks_hi) to_err <= 1'b1;
                    end else begin
                        cnt <= cnt_inc[TO_W-1:0];
                    end
                end
                RTZ: begin
                    if (acks_lo) begin
                        state <= all_null ? DAT : NUL;
                    end else if (timeout) begin
                        state  <= NUL;
                        to_err <= 1'b1;
                    end else begin
                        cnt <= cnt_inc[TO_W-1:0];
                    end
                end
                default: state <= NUL;
            endcase
        end
    end

endmodule

// File: doc/dr_phase_ctrl.md
Name: dr_phase_ctrl

Overview:
- Clocked, parametrised successor of the dual-rail phase controller.
- Samples N dual-rail command pairs and the two dual-rail phase pairs (PH0, PH1).
- Detects DATA/NULL wavefront completion and decodes the core request (R_c) and memory request (R_m) as registered dual-rail outputs.
- Runs a four-phase return-to-zero handshake with core/memory acks, with illegal-code and timeout error detection. Sits between the phase sequencer and the core/memory request logic.

Parameters:
NCH, 2, number of dual-rail command pairs (min 2)
RD_IDX, 0, command pair index used as Rd
LD_IDX, 1, command pair index used as Ld
TO_W, 8, timeout counter width
TO_MAX, 200, cycles allowed in REQ or RTZ before timeout (1..2^TO_W-1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
ph_t  in  2  phase true rails, bit0=PH0, bit1=PH1
ph_f  in  2  phase false rails
cmd_t  in  NCH  command true rails
cmd_f  in  NCH  command false rails
ack_c  in  1  core ack, single-rail
ack_m  in  1  memory ack, single-rail
err_clr  in  1  clears sticky error flags
r_c_t  out  1  core request, true rail
r_c_f  out  1  core request, false rail
r_m_t  out  1  memory request, true rail
r_m_f  out  1  memory request, false rail
busy  out  1  high in any state other than NUL
code_err  out  1  sticky: illegal 11 code seen
to_err  out  1  sticky: handshake timeout

Behaviour:
- Pair encoding (t,f): 00 NULL, 10 TRUE, 01 FALSE, 11 ILLEGAL.
- all_data: every ph and cmd pair is TRUE or FALSE. all_null: every pair is 00.
- Reset: state=NUL; all outputs 0; timeout counter 0.
- NUL: outputs NULL. all_null -> DAT.
- DAT: outputs NULL. Any ILLEGAL pair -> set code_err, stay in DAT (error has priority over completion in the same cycle). all_data and no ILLEGAL -> REQ; outputs are registered and present one cycle after completion is sampled.
- Decode, latched on entry to REQ and held through REQ:
  - R_c TRUE iff PH0 FALSE and PH1 TRUE and cmd[RD_IDX] TRUE; otherwise R_c FALSE.
  - R_m TRUE iff PH0 TRUE, or (PH1 TRUE and cmd[LD_IDX] TRUE); otherwise R_m FALSE.
  - Exactly one rail of each output pair is high.
- REQ: wait for ack_c and ack_m both high -> RTZ; outputs go NULL on the next edge.
- RTZ: outputs NULL. Both acks low and all_null -> DAT. Both acks low but inputs not yet NULL -> NUL.
- Timeout: the counter clears on entry to REQ and on entry to RTZ, and increments each cycle in those states. When count==TO_MAX: set to_err, outputs NULL, state -> NUL.
- Errors: err_clr clears both sticky flags. If a set and err_clr occur in the same cycle, set wins.
- Pairs beyond RD_IDX/LD_IDX take part in completion detection only.
- Asserting rst mid-handshake forces NUL and NULL outputs immediately (asynchronous).

Optional Feature:
- Macro DR_SYNC_EN.
- Defined: every ph/cmd rail and both acks pass through a 2-flop synchroniser, also reset by rst. All latencies grow by 2 cycles.
- Undefined: inputs are sampled directly; the caller guarantees they are synchronous to clk.

Test Plan:
1. Reset, then all inputs NULL -> state reaches DAT after 1 clk; all outputs 0; busy=1.
2. PH0=FALSE, PH1=TRUE, Rd=TRUE, Ld=FALSE -> 1 clk later r_c_t=1, r_m_f=1; both acks high -> next clk outputs 0000; acks low with inputs NULL -> back in DAT.
3. PH0=TRUE, PH1=FALSE, Rd=FALSE, Ld=FALSE -> r_c_f=1, r_m_t=1.
4. ph_t[1]=ph_f[1]=1 with other pairs valid -> code_err=1, no request issued; err_clr pulse -> code_err=0.
5. Valid DATA with acks held low, TO_MAX=200 -> to_err=1 exactly 200 clks after REQ entry; outputs 0000; state NUL.
6. rst asserted while in REQ with r_m_t=1 -> r_m_t drops to 0 with no clock edge; busy=0.
